// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad input port: debounce states,
// counter sizing and key-code zero extension.
package keypad_pkg;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_ARM,
    DB_HELD,
    DB_REL
  } db_state_t;

  // Widest word the zero-extend helper can produce; DATA_W must not exceed it.
  localparam int unsigned ZEXT_MAX_W = 64;

  // Bits needed to hold the value max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Keeps the low w bits of v, clears the rest.
  function automatic logic [ZEXT_MAX_W-1:0] zext(input logic [ZEXT_MAX_W-1:0] v,
                                                 input int unsigned w);
    logic [ZEXT_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < ZEXT_MAX_W; i++) begin
      if (i < w) r[i] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Strobe synchroniser and debounce FSM: one o_key_pulse per debounced press,
// with the key code carried through its own synchroniser.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [KEY_W-1:0] i_key_code,
  input  logic             i_key_valid,
  output logic             o_key_pulse,
  output logic [KEY_W-1:0] o_key_code
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYC);

  logic [SYNC_STAGES-1:0] r_valid_sync;
  logic [KEY_W-1:0]       r_key_sync [SYNC_STAGES];
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  db_state_t              r_state;
  db_state_t              w_state_nxt;
  logic                   w_sync;
  logic                   w_cnt_done;

  assign w_sync     = r_valid_sync[SYNC_STAGES-1];
  assign w_cnt_done = (r_cnt == CW'(DEBOUNCE_CYC));
  // Settled code; valid whenever o_key_pulse is high since the strobe is long stable.
  assign o_key_code = r_key_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_key_sync[i] <= '0;
      r_state      <= DB_IDLE;
      r_cnt        <= '0;
    end else begin
      r_valid_sync  <= {r_valid_sync[SYNC_STAGES-2:0], i_key_valid};
      r_key_sync[0] <= i_key_code;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_key_sync[i] <= r_key_sync[i-1];
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_key_pulse = 1'b0;
    case (r_state)
      DB_IDLE: begin
        if (w_sync) begin
          w_state_nxt = DB_ARM;
          w_cnt_nxt   = CW'(1);
        end
      end
      DB_ARM: begin
        if (!w_sync) begin
          w_state_nxt = DB_IDLE;
        end else if (w_cnt_done) begin
          w_state_nxt = DB_HELD;
          o_key_pulse = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DB_HELD: begin
        if (!w_sync) begin
          w_state_nxt = DB_REL;
          w_cnt_nxt   = CW'(1);
        end
      end
      DB_REL: begin
        if (w_sync) begin
          w_state_nxt = DB_HELD;
        end else if (w_cnt_done) begin
          w_state_nxt = DB_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = DB_IDLE;
    endcase
  end

endmodule

// File: rtl/keypad_fifo_if.sv
// Keypad/processor input port: debounced key capture plus processor pushes
// into a first-word-fall-through FIFO with registered flags.
module keypad_fifo_if
  import keypad_pkg::*;
#(
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [KEY_W-1:0]         KEY_CODE,
  input  logic                     KEY_VALID,
  input  logic                     WE_Procesador,
  input  logic [DATA_W-1:0]        ProcesadorIN,
  input  logic                     RD_Procesador,
  input  logic                     CLR_OVF,
  output logic [DATA_W-1:0]        OUT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic              w_key_pulse;
  logic [KEY_W-1:0]  w_key_code;
  logic [DATA_W-1:0] w_key_word;

  logic              r_pend_valid;
  logic [DATA_W-1:0] r_pend_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_out;
  logic              r_empty;
  logic              r_full;
  logic              r_ovf;

  logic              w_push_req;
  logic [DATA_W-1:0] w_push_data;
  logic              w_pend_load;
  logic              w_pend_clear;
  logic              w_key_drop;
  logic              w_do_push;
  logic              w_do_pop;
  logic [AW-1:0]     w_wr_nxt;
  logic [AW-1:0]     w_rd_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic [DATA_W-1:0] w_head;
  logic              w_ovf_nxt;

  keypad_debounce #(
    .KEY_W       (KEY_W),
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .i_clk      (CLK),
    .i_rst_n    (RESET),
    .i_key_code (KEY_CODE),
    .i_key_valid(KEY_VALID),
    .o_key_pulse(w_key_pulse),
    .o_key_code (w_key_code)
  );

  assign w_key_word = DATA_W'(zext(ZEXT_MAX_W'(w_key_code), KEY_W));

  assign OUT      = r_out;
  assign EMPTY    = r_empty;
  assign FULL     = r_full;
  assign COUNT    = r_count;
  assign OVERFLOW = r_ovf;

  // Processor write wins; a colliding key waits one slot in the pending register.
  always_comb begin
    w_push_req   = 1'b0;
    w_push_data  = '0;
    w_pend_load  = 1'b0;
    w_pend_clear = 1'b0;
    w_key_drop   = 1'b0;
    if (WE_Procesador) begin
      w_push_req  = 1'b1;
      w_push_data = ProcesadorIN;
      if (w_key_pulse) begin
        if (r_pend_valid) w_key_drop  = 1'b1;
        else              w_pend_load = 1'b1;
      end
    end else if (r_pend_valid) begin
      w_push_req   = 1'b1;
      w_push_data  = r_pend_data;
      w_pend_clear = 1'b1;
      w_key_drop   = w_key_pulse;
    end else if (w_key_pulse) begin
      w_push_req  = 1'b1;
      w_push_data = w_key_word;
    end
  end

  always_comb begin
    w_do_pop  = RD_Procesador && !r_empty;
    w_do_push = w_push_req && (!r_full || w_do_pop);
    w_wr_nxt  = w_do_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
    w_rd_nxt  = w_do_pop  ? r_rd_ptr + 1'b1 : r_rd_ptr;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
    // The new head can be the slot being written this cycle; bypass the array.
    w_head = (w_do_push && (w_rd_nxt == r_wr_ptr)) ? w_push_data : r_mem[w_rd_nxt];
    if ((w_push_req && !w_do_push) || w_key_drop) w_ovf_nxt = 1'b1;
    else if (CLR_OVF)                              w_ovf_nxt = 1'b0;
    else                                           w_ovf_nxt = r_ovf;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out        <= '0;
      r_empty      <= 1'b1;
      r_full       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (w_do_push) r_mem[r_wr_ptr] <= w_push_data;
      if (w_pend_load) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= w_key_word;
      end else if (w_pend_clear) begin
        r_pend_valid <= 1'b0;
      end
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_out    <= (w_count_nxt == '0) ? '0 : w_head;
      r_empty  <= (w_count_nxt == '0);
      r_full   <= (w_count_nxt == CW'(DEPTH));
      r_ovf    <= w_ovf_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_fifo_if.sv
// Directed bench for keypad_fifo_if: vector table for FIFO behaviour plus
// hand-timed sequences for debounce, collision and reset corner cases.
module tb_keypad_fifo_if;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        WE_Procesador;
  logic [31:0] ProcesadorIN;
  logic        RD_Procesador;
  logic        CLR_OVF;
  logic [31:0] OUT;
  logic        EMPTY;
  logic        FULL;
  logic [3:0]  COUNT;
  logic        OVERFLOW;

  int n_cmp  = 0;
  int n_fail = 0;

  keypad_fifo_if #(
    .KEY_W       (4),
    .DATA_W      (32),
    .DEPTH       (8),
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(16)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KEY_CODE     (KEY_CODE),
    .KEY_VALID    (KEY_VALID),
    .WE_Procesador(WE_Procesador),
    .ProcesadorIN (ProcesadorIN),
    .RD_Procesador(RD_Procesador),
    .CLR_OVF      (CLR_OVF),
    .OUT          (OUT),
    .EMPTY        (EMPTY),
    .FULL         (FULL),
    .COUNT        (COUNT),
    .OVERFLOW     (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] din;
    logic        rd;
    logic        clr;
    logic [31:0] e_out;
    logic        e_empty;
    logic        e_full;
    logic [3:0]  e_count;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic we, input logic [31:0] din, input logic rd, input logic clr,
                     input logic [31:0] e_out, input logic e_empty, input logic e_full,
                     input logic [3:0] e_count, input logic e_ovf);
    vecs.push_back('{we, din, rd, clr, e_out, e_empty, e_full, e_count, e_ovf});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    KEY_CODE      = 4'h0;
    KEY_VALID     = 1'b0;
    WE_Procesador = 1'b0;
    ProcesadorIN  = 32'h0;
    RD_Procesador = 1'b0;
    CLR_OVF       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RESET = 1'b0;
    tick(2);
    RESET = 1'b1;
    tick(1);
  endtask

  initial begin
    // FIFO table: fill/overflow, drain, wrap refill, full push+pop, empty corners
    for (int k = 1; k <= 8; k++) add(1'b1, 32'(k), 1'b0, 1'b0, 32'h1, 1'b0, k == 8, 4'(k), 1'b0);
    add(1'b1, 32'h9, 1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 4'd8, 1'b1);
    for (int j = 1; j <= 8; j++)
      add(1'b0, 32'h0, 1'b1, 1'b0, (j < 8) ? 32'(j + 1) : 32'h0, j == 8, 1'b0, 4'(8 - j), 1'b1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b1);
    add(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b1, 32'(k), 1'b0, 1'b0, 32'h1, 1'b0, k == 8, 4'(k), 1'b0);
    add(1'b1, 32'h9, 1'b1, 1'b0, 32'h2, 1'b0, 1'b1, 4'd8, 1'b0);
    for (int j = 1; j <= 8; j++)
      add(1'b0, 32'h0, 1'b1, 1'b0, (j < 8) ? 32'(j + 2) : 32'h0, j == 8, 1'b0, 4'(8 - j), 1'b0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0);
    add(1'b1, 32'h5, 1'b1, 1'b0, 32'h5, 1'b0, 1'b0, 4'd1, 1'b0);
    add(1'b1, 32'h6, 1'b1, 1'b0, 32'h6, 1'b0, 1'b0, 4'd1, 1'b0);
    add(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 1'b0);

    // 1: reset held with random inputs
    idle_inputs();
    RESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      KEY_CODE      = 4'($urandom);
      KEY_VALID     = 1'($urandom);
      WE_Procesador = 1'($urandom);
      ProcesadorIN  = $urandom;
      RD_Procesador = 1'($urandom);
      CLR_OVF       = 1'($urandom);
      tick(1);
      chk($sformatf("rst%0d.out", i), OUT, 32'h0);
      chk($sformatf("rst%0d.empty", i), 32'(EMPTY), 32'h1);
      chk($sformatf("rst%0d.full", i), 32'(FULL), 32'h0);
      chk($sformatf("rst%0d.count", i), 32'(COUNT), 32'h0);
      chk($sformatf("rst%0d.ovf", i), 32'(OVERFLOW), 32'h0);
    end
    do_reset();

    // 2a: press-to-FIFO latency is SYNC_STAGES+DEBOUNCE_CYC+1 = 19 edges
    KEY_CODE  = 4'h5;
    KEY_VALID = 1'b1;
    tick(18);
    chk("lat.count18", 32'(COUNT), 32'h0);
    tick(1);
    chk("lat.count19", 32'(COUNT), 32'h1);
    chk("lat.out19", OUT, 32'h5);
    KEY_VALID = 1'b0;
    tick(25);
    do_reset();

    // 2b: bouncing strobe, then long hold -> single entry
    KEY_CODE = 4'hA;
    for (int i = 0; i < 20; i++) begin
      KEY_VALID = ((i / 3) % 2) == 0;
      tick(1);
    end
    KEY_VALID = 1'b0;
    tick(3);
    chk("bounce.count_during", 32'(COUNT), 32'h0);
    KEY_VALID = 1'b1;
    tick(40);
    chk("bounce.count", 32'(COUNT), 32'h1);
    chk("bounce.out", OUT, 32'h0000000A);
    KEY_VALID = 1'b0;
    tick(25);
    chk("bounce.count_after_release", 32'(COUNT), 32'h1);
    chk("bounce.ovf", 32'(OVERFLOW), 32'h0);

    // 3 and 5: table-driven FIFO vectors
    do_reset();
    foreach (vecs[i]) begin
      WE_Procesador = vecs[i].we;
      ProcesadorIN  = vecs[i].din;
      RD_Procesador = vecs[i].rd;
      CLR_OVF       = vecs[i].clr;
      tick(1);
      chk($sformatf("v%0d.out", i), OUT, vecs[i].e_out);
      chk($sformatf("v%0d.empty", i), 32'(EMPTY), 32'(vecs[i].e_empty));
      chk($sformatf("v%0d.full", i), 32'(FULL), 32'(vecs[i].e_full));
      chk($sformatf("v%0d.count", i), 32'(COUNT), 32'(vecs[i].e_count));
      chk($sformatf("v%0d.ovf", i), 32'(OVERFLOW), 32'(vecs[i].e_ovf));
    end
    idle_inputs();

    // 4: key pulse collides with processor write -> DEAD then 3
    do_reset();
    KEY_CODE  = 4'h3;
    KEY_VALID = 1'b1;
    tick(18);
    WE_Procesador = 1'b1;
    ProcesadorIN  = 32'h0000DEAD;
    tick(1);
    WE_Procesador = 1'b0;
    chk("coll.count1", 32'(COUNT), 32'h1);
    chk("coll.out1", OUT, 32'h0000DEAD);
    tick(1);
    chk("coll.count2", 32'(COUNT), 32'h2);
    chk("coll.out2", OUT, 32'h0000DEAD);
    RD_Procesador = 1'b1;
    tick(1);
    RD_Procesador = 1'b0;
    chk("coll.out3", OUT, 32'h00000003);
    chk("coll.count3", 32'(COUNT), 32'h1);
    chk("coll.ovf", 32'(OVERFLOW), 32'h0);
    KEY_VALID = 1'b0;
    tick(25);
    chk("coll.count_final", 32'(COUNT), 32'h1);

    // 6: reset mid-FIFO and mid-ARM
    do_reset();
    WE_Procesador = 1'b1;
    ProcesadorIN  = 32'h00000077;
    tick(1);
    WE_Procesador = 1'b0;
    chk("midrst.count_pre", 32'(COUNT), 32'h1);
    KEY_CODE  = 4'h7;
    KEY_VALID = 1'b1;
    tick(7);
    #2;
    RESET     = 1'b0;
    KEY_VALID = 1'b0;
    #1;
    chk("midrst.count_async", 32'(COUNT), 32'h0);
    chk("midrst.empty_async", 32'(EMPTY), 32'h1);
    chk("midrst.out_async", OUT, 32'h0);
    tick(1);
    RESET = 1'b1;
    tick(40);
    chk("midrst.count_final", 32'(COUNT), 32'h0);
    chk("midrst.empty_final", 32'(EMPTY), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
